// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer: FSM states, pattern
// select codes and the data pattern function.
package sram_test_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    WR_ACK   = 3'd2,
    WR_DRAIN = 3'd3,
    RD_REQ   = 3'd4,
    RD_ACK   = 3'd5,
    RD_DRAIN = 3'd6,
    DONE     = 3'd7
  } state_e;

  localparam logic [1:0] PAT_ADDR    = 2'd0;  // low address byte
  localparam logic [1:0] PAT_INV     = 2'd1;  // inverted low address byte
  localparam logic [1:0] PAT_CHECKER = 2'd2;  // 0x55 on even, 0xAA on odd
  localparam logic [1:0] PAT_ZERO    = 2'd3;  // all zeros

  // Data byte written to (and expected back from) a given address.
  function automatic logic [7:0] pattern_byte(input logic [7:0] addr_lo,
                                              input logic [1:0] sel);
    logic [7:0] p;
    case (sel)
      PAT_ADDR:    p = addr_lo;
      PAT_INV:     p = ~addr_lo;
      PAT_CHECKER: p = addr_lo[0] ? 8'hAA : 8'h55;
      default:     p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sram_pattern_gen.sv
// Combinational test-pattern generator: maps the low address byte and the
// selected pattern code onto a data word.
module sram_pattern_gen
  import sram_test_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        addr_lo,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] pattern
);

  assign pattern = DATA_W'(pattern_byte(addr_lo, pattern_sel));

endmodule

// File: rtl/sram_test_seq.sv
// SRAM test sequencer: writes a pattern to addresses 0..ADDR_LAST through an
// SRAM controller, reads every address back, compares and logs errors.
//
// Controller handshake: a request is a single-cycle start_operation pulse with
// rw/address_input/data_f2s valid in that cycle (and held afterwards). A write
// is acknowledged by a writing_finished pulse, a read by a data_ready pulse
// with data_s2f valid in that same cycle. After either acknowledge the
// sequencer waits for busy=0 before issuing the next request. Every ACK/DRAIN
// wait is bounded by TIMEOUT cycles.
module sram_test_seq
  import sram_test_pkg::*;
#(
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(19'h7FFFF),
  parameter int                TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [1:0]        pattern_sel,
  output logic              start_operation,
  output logic              rw,
  output logic [ADDR_W-1:0] address_input,
  output logic [DATA_W-1:0] data_f2s,
  input  logic [DATA_W-1:0] data_s2f,
  input  logic              data_ready,
  input  logic              writing_finished,
  input  logic              busy,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output state_e            state_dbg
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pat_q, pat_d;
  logic [TMO_W-1:0]  tmo_q;
  logic              is_wait, tmo_hit, tmo_fire, rd_cmp, mismatch, start_pass;
  logic [DATA_W-1:0] pat_exp;

  // Pattern for the address about to be used; in RD_ACK addr_d == addr_q,
  // so the same generator also provides the compare value.
  sram_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
    .addr_lo     (addr_d[7:0]),
    .pattern_sel (pat_d),
    .pattern     (pat_exp)
  );

  assign is_wait = (state_q == WR_ACK) || (state_q == WR_DRAIN) ||
                   (state_q == RD_ACK) || (state_q == RD_DRAIN);
  assign tmo_hit         = is_wait && (tmo_q == TMO_LAST);
  assign start_pass      = (state_q == IDLE) && go;
  assign mismatch        = rd_cmp && (data_s2f != pat_exp);
  assign start_operation = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign state_dbg       = state_q;

  // Next-state, next-address and compare strobe
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pat_d    = pat_q;
    tmo_fire = 1'b0;
    rd_cmp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = WR_REQ;
          addr_d  = '0;
          pat_d   = pattern_sel;
        end
      end
      WR_REQ: state_d = WR_ACK;
      WR_ACK: begin
        if (writing_finished) state_d = WR_DRAIN;
        else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      WR_DRAIN: begin
        if (!busy) begin
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = WR_REQ;
          end
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      RD_REQ: state_d = RD_ACK;
      RD_ACK: begin
        if (data_ready) begin
          rd_cmp  = 1'b1;
          state_d = RD_DRAIN;
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (!busy) begin
          if (addr_q == ADDR_LAST) state_d = DONE;
          else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD_REQ;
          end
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, address counter, latched pattern code and wait timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      if (state_d != state_q) tmo_q <= '0;
      else if (is_wait)       tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Request fields are loaded on entry to a request state and then held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw            <= 1'b0;
      address_input <= '0;
      data_f2s      <= '0;
    end else if (state_d == WR_REQ) begin
      rw            <= 1'b0;
      address_input <= addr_d;
      data_f2s      <= pat_exp;
    end else if (state_d == RD_REQ) begin
      rw            <= 1'b1;
      address_input <= addr_d;
    end
  end

  // Status flags and error log; cleared by go, frozen after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running        <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else if (start_pass) begin
      running        <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_err_addr <= addr_q;
          first_err_exp  <= pat_exp;
          first_err_got  <= data_s2f;
        end
      end
      if ((state_d == DONE) && (state_q != DONE)) begin
        running <= 1'b0;
        done    <= 1'b1;
        timeout <= tmo_fire;
        pass    <= (err_count == 16'd0) && !tmo_fire;
      end
    end
  end

endmodule

// File: tb/tb_sram_test_seq.sv
// Bench for sram_test_seq: a behavioural SRAM controller answers requests,
// a monitor checks every request and every completed pass against queued
// expectations, and directed sequences cover reset, timeout and ADDR_LAST=0.
`timescale 1ns/1ps
module tb_sram_test_seq;
  import sram_test_pkg::*;

  localparam int AW  = 19;
  localparam int DW  = 8;
  localparam int W   = 1 + AW + DW;                 // {rw, addr, data}
  localparam int SW  = 1 + 1 + 16 + AW + DW + DW;   // {pass, tmo, err, fa, fe, fg}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic go_a = 1'b0, go_b = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [DW-1:0] data_s2f;
  logic data_ready, writing_finished, busy;

  logic a_start, a_rw, a_running, a_done, a_pass, a_timeout;
  logic [AW-1:0] a_addr, a_faddr;
  logic [DW-1:0] a_data, a_fexp, a_fgot;
  logic [15:0] a_err;
  state_e a_state;

  logic b_start, b_rw, b_running, b_done, b_pass, b_timeout;
  logic [AW-1:0] b_addr, b_faddr;
  logic [DW-1:0] b_data, b_fexp, b_fgot;
  logic [15:0] b_err;
  state_e b_state;

  sram_test_seq #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(19'd7), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .pattern_sel(pattern_sel),
    .start_operation(a_start), .rw(a_rw), .address_input(a_addr), .data_f2s(a_data),
    .data_s2f(data_s2f), .data_ready(data_ready), .writing_finished(writing_finished),
    .busy(busy), .running(a_running), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .err_count(a_err), .first_err_addr(a_faddr), .first_err_exp(a_fexp),
    .first_err_got(a_fgot), .state_dbg(a_state));

  sram_test_seq #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(19'd0), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .pattern_sel(pattern_sel),
    .start_operation(b_start), .rw(b_rw), .address_input(b_addr), .data_f2s(b_data),
    .data_s2f(data_s2f), .data_ready(data_ready), .writing_finished(writing_finished),
    .busy(busy), .running(b_running), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .err_count(b_err), .first_err_addr(b_faddr), .first_err_exp(b_fexp),
    .first_err_got(b_fgot), .state_dbg(b_state));

  // Selected DUT as seen by the controller model and the monitor
  logic sel_b = 1'b0;
  logic m_start, m_rw, m_running, m_done, m_pass, m_timeout;
  logic [AW-1:0] m_addr, m_faddr;
  logic [DW-1:0] m_data, m_fexp, m_fgot;
  logic [15:0] m_err;
  state_e m_state;
  always_comb begin
    if (sel_b) begin
      m_start = b_start; m_rw = b_rw; m_addr = b_addr; m_data = b_data;
      m_running = b_running; m_done = b_done; m_pass = b_pass; m_timeout = b_timeout;
      m_err = b_err; m_faddr = b_faddr; m_fexp = b_fexp; m_fgot = b_fgot; m_state = b_state;
    end else begin
      m_start = a_start; m_rw = a_rw; m_addr = a_addr; m_data = a_data;
      m_running = a_running; m_done = a_done; m_pass = a_pass; m_timeout = a_timeout;
      m_err = a_err; m_faddr = a_faddr; m_fexp = a_fexp; m_fgot = a_fgot; m_state = a_state;
    end
  end

  // ---------------- SRAM controller model ----------------
  logic [7:0] mem [0:255];
  logic wf_en = 1'b1;
  logic corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [2:0] ph;
  logic op_rw;
  logic [AW-1:0] op_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 3'd0; busy <= 1'b0; writing_finished <= 1'b0; data_ready <= 1'b0;
      data_s2f <= '0; op_rw <= 1'b0; op_addr <= '0;
    end else begin
      case (ph)
        3'd0: if (m_start) begin
          busy <= 1'b1; ph <= 3'd1; op_rw <= m_rw; op_addr <= m_addr;
          if (!m_rw) mem[m_addr[7:0]] <= m_data;
        end
        3'd1: ph <= 3'd2;
        3'd2: begin
          if (op_rw) begin
            data_ready <= 1'b1;
            data_s2f   <= (corrupt_en && op_addr == corrupt_addr) ? 8'hFF : mem[op_addr[7:0]];
          end else if (wf_en) writing_finished <= 1'b1;
          ph <= 3'd3;
        end
        3'd3: begin data_ready <= 1'b0; writing_finished <= 1'b0; ph <= 3'd4; end
        default: begin busy <= 1'b0; ph <= 3'd0; end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] st_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pat(input logic [7:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return a;
      2'd1:    return ~a;
      2'd2:    return a[0] ? 8'hAA : 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: checks each request and each completed pass
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [SW-1:0] s;
    if (rst_n && m_start) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_request got rw=%0d addr=%0h required none", m_rw, m_addr);
      end else begin
        e = exp_q.pop_front();
        check("req_rw", 64'(m_rw), 64'(e[W-1]));
        check("req_addr", 64'(m_addr), 64'(e[W-2 -: AW]));
        if (!e[W-1]) check("req_data", 64'(m_data), 64'(e[DW-1:0]));
      end
    end
    if (rst_n && m_done && !done_prev) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done got done=1 required no completion");
      end else begin
        s = st_q.pop_front();
        check("st_pass", 64'(m_pass), 64'(s[SW-1]));
        check("st_timeout", 64'(m_timeout), 64'(s[SW-2]));
        check("st_err_count", 64'(m_err), 64'(s[SW-3 -: 16]));
        check("st_first_err_addr", 64'(m_faddr), 64'(s[2*DW+AW-1 -: AW]));
        check("st_first_err_exp", 64'(m_fexp), 64'(s[2*DW-1 -: DW]));
        check("st_first_err_got", 64'(m_fgot), 64'(s[DW-1:0]));
        check("st_running_low", 64'(m_running), 64'd0);
      end
    end
    done_prev <= m_done;
  end

  // ---------------- driver tasks ----------------
  task automatic push_reqs(input int last, input logic [1:0] sel, input int n_reads);
    for (int i = 0; i <= last; i++) exp_q.push_back({1'b0, AW'(i), exp_pat(i[7:0], sel)});
    for (int i = 0; i < n_reads; i++) exp_q.push_back({1'b1, AW'(i), 8'h00});
  endtask

  task automatic push_status(input logic p, input logic t, input logic [15:0] err,
                             input logic [AW-1:0] fa, input logic [DW-1:0] fe,
                             input logic [DW-1:0] fg);
    st_q.push_back({p, t, err, fa, fe, fg});
  endtask

  task automatic pulse_go(input logic b);
    @(negedge clk);
    if (b) go_b = 1'b1; else go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0; go_b = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!m_done && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(m_done), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_state(input state_e st, input int addr, input string name);
    int n = 0;
    while (!(m_state == st && (addr < 0 || m_addr == AW'(addr))) && n < 3000) begin
      @(negedge clk); n++;
    end
    check(name, 64'(m_state), 64'(st));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 64'(m_state), 64'(IDLE));
    check({tag, "_start"}, 64'(m_start), 64'd0);
    check({tag, "_rw"}, 64'(m_rw), 64'd0);
    check({tag, "_addr"}, 64'(m_addr), 64'd0);
    check({tag, "_data"}, 64'(m_data), 64'd0);
    check({tag, "_flags"}, 64'({m_running, m_done, m_pass, m_timeout}), 64'd0);
    check({tag, "_err_log"}, 64'({m_err, m_faddr, m_fexp, m_fgot}), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t1, n;

    // Reset values on both instances, then idle without go
    #2;
    check_zero("reset_a");
    sel_b = 1'b1; #1;
    check_zero("reset_b");
    sel_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_without_go", 64'(a_state), 64'(IDLE));

    // Pattern 0, ideal controller: writes 0..7 then 8 reads, pass
    pattern_sel = 2'd0;
    push_reqs(7, 2'd0, 8);
    push_status(1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00);
    pulse_go(1'b0);
    wait_done("done_pat0");
    check("done_held_in_idle", 64'({a_state, a_done, a_pass}), 64'({IDLE, 1'b1, 1'b1}));

    // Pattern 1, ideal controller
    pattern_sel = 2'd1;
    push_reqs(7, 2'd1, 8);
    push_status(1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00);
    pulse_go(1'b0);
    wait_done("done_pat1");

    // Pattern 0, corrupt read at address 3
    pattern_sel = 2'd0;
    corrupt_en = 1'b1; corrupt_addr = 19'd3;
    push_reqs(7, 2'd0, 8);
    push_status(1'b0, 1'b0, 16'd1, 19'd3, 8'h03, 8'hFF);
    pulse_go(1'b0);
    wait_done("done_corrupt3");

    // Pattern 2, corrupt read at odd address 5 (expects 0xAA)
    pattern_sel = 2'd2;
    corrupt_addr = 19'd5;
    push_reqs(7, 2'd2, 8);
    push_status(1'b0, 1'b0, 16'd1, 19'd5, 8'hAA, 8'hFF);
    pulse_go(1'b0);
    wait_done("done_corrupt5");
    corrupt_en = 1'b0;

    // Controller never finishes a write: timeout after exactly 64 cycles
    pattern_sel = 2'd3;
    wf_en = 1'b0;
    push_reqs(0, 2'd3, 0);
    push_status(1'b0, 1'b1, 16'd0, 19'd0, 8'h00, 8'h00);
    pulse_go(1'b0);
    wait_state(WR_ACK, -1, "enter_wr_ack");
    t0 = cyc;
    n = 0;
    while (!a_timeout && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    check("timeout_latency", 64'(t1 - t0), 64'd64);
    check("timeout_done", 64'({a_done, a_pass}), 64'({1'b1, 1'b0}));
    wait_done("done_timeout");
    wf_en = 1'b1;

    // Reset during RD_ACK at address 5, then a clean restart
    pattern_sel = 2'd0;
    push_reqs(7, 2'd0, 6);
    pulse_go(1'b0);
    wait_state(RD_ACK, 5, "reach_rd_ack_5");
    rst_n = 1'b0;
    #1;
    check_zero("midpass_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("queue_drained_at_reset", 64'(exp_q.size()), 64'd0);
    push_reqs(7, 2'd0, 8);
    push_status(1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00);
    pulse_go(1'b0);
    wait_done("done_after_reset");

    // ADDR_LAST=0 instance, pattern 2: one write of 0x55, one read; go ignored mid-pass
    sel_b = 1'b1;
    pattern_sel = 2'd2;
    push_reqs(0, 2'd2, 1);
    push_status(1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00);
    pulse_go(1'b1);
    wait_state(WR_ACK, -1, "b_enter_wr_ack");
    pulse_go(1'b1);
    check("b_running_after_extra_go", 64'(b_running), 64'd1);
    wait_done("done_b");
    repeat (10) @(negedge clk);

    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("status_queue_empty", 64'(st_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_test_seq.md
SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 19, SRAM address width; DATA_W, 8, SRAM data width; ADDR_LAST, 19'h7FFFF, last address tested; TIMEOUT, 64, max cycles to wait for controller completion.
REQ-002 Ports (name, direction, width, meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 go in 1 — single-cycle pulse starts a test pass.
REQ-004 pattern_sel in 2 — 0: addr[7:0]; 1: ~addr[7:0]; 2: addr[0] ? 8'hAA : 8'h55; 3: 8'h00.
REQ-005 start_operation out 1, rw out 1 (1 = read), address_input out ADDR_W, data_f2s out DATA_W — request side toward the SRAM controller.
REQ-006 data_s2f in DATA_W, data_ready in 1, writing_finished in 1, busy in 1 — response side from the SRAM controller.
REQ-007 running out 1, done out 1, pass out 1, timeout out 1 — status flags.
REQ-008 err_count out 16 (saturating), first_err_addr out ADDR_W, first_err_exp out DATA_W, first_err_got out DATA_W — error log.

Function
REQ-009 FSM states: IDLE, WR_REQ, WR_ACK, WR_DRAIN, RD_REQ, RD_ACK, RD_DRAIN, DONE.
REQ-010 IDLE: on go=1 clear done/pass/timeout/err_count/first_err_*, addr counter := 0, running := 1, go to WR_REQ; go in any other state is ignored.
REQ-011 WR_REQ: one cycle with start_operation=1, rw=0, address_input=addr, data_f2s=pattern(addr); then WR_ACK.
REQ-012 WR_ACK: wait for writing_finished=1, then WR_DRAIN; WR_DRAIN: wait for busy=0.
REQ-013 On leaving WR_DRAIN: if addr==ADDR_LAST, addr := 0 and go to RD_REQ; else addr := addr+1 and go to WR_REQ.
REQ-014 RD_REQ: one cycle with start_operation=1, rw=1, address_input=addr; then RD_ACK.
REQ-015 RD_ACK: in the cycle data_ready=1, compare data_s2f with pattern(addr); then go to RD_DRAIN, which waits for busy=0.
REQ-016 On mismatch: err_count increments, saturating at 16'hFFFF; if err_count was 0, capture addr, expected and got values into first_err_*.
REQ-017 On leaving RD_DRAIN: if addr==ADDR_LAST go to DONE; else addr := addr+1 and go to RD_REQ.
REQ-018 start_operation SHALL be high only in WR_REQ/RD_REQ; address_input, data_f2s and rw hold their values from the request until the next request.
REQ-019 Timeout counter resets on entry to each ACK/DRAIN state; if it reaches TIMEOUT, set timeout=1 and go to DONE.
REQ-020 DONE: running=0, done=1, pass = (err_count==0 && !timeout); return to IDLE next cycle; done, pass and the error log hold until the next go.
REQ-021 ADDR_LAST=0 SHALL test exactly one address; the addr counter never exceeds ADDR_LAST.

Reset
REQ-022 rst_n=0 asynchronously forces IDLE; all outputs and counters go to 0, including during a pass in flight.
REQ-023 After reset release, the block stays in IDLE until go.

Structure
REQ-024 State encoding, pattern_sel codes and the pattern function belong in shared package sram_test_pkg.
REQ-025 One sub-module: sram_pattern_gen (combinational pattern from addr and pattern_sel); the FSM stays in sram_test_seq.

Verification
REQ-026 ADDR_LAST=7, pattern 0, ideal controller model -> 8 writes with data 0..7, then 8 reads; done=1, pass=1, err_count=0.
REQ-027 Same, with the model returning 8'hFF at addr 3 -> err_count=1, first_err_addr=3, first_err_exp=8'h03, first_err_got=8'hFF, pass=0.
REQ-028 Model never asserts writing_finished -> timeout=1 exactly TIMEOUT cycles after WR_ACK entry, done=1, pass=0.
REQ-029 rst_n low during RD_ACK at addr 5 -> all outputs 0 immediately; the next go restarts from addr 0 with a write.
REQ-030 ADDR_LAST=0, pattern 2 -> one write of 8'h55, one read; go pulsed while running has no effect.
